// File: rtl/uart_echo_pkg.sv
// Shared mode encodings, ASCII constants and the case-folding helper
// used by the buffered UART echo engine.
package uart_echo_pkg;

    typedef enum logic [1:0] {
        MODE_CHAR  = 2'd0,
        MODE_LINE  = 2'd1,
        MODE_UPPER = 2'd2,
        MODE_RSVD  = 2'd3
    } echo_mode_e;

    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LC_A = 8'h61;
    localparam logic [7:0] ASCII_LC_Z = 8'h7A;
    localparam int         CASE_BIT   = 5;

    // Lowercase ASCII letters lose the case bit; everything else passes through.
    function automatic logic [7:0] to_upper(input logic [7:0] b);
        logic [7:0] r;
        r = b;
        if (b >= ASCII_LC_A && b <= ASCII_LC_Z) begin
            r[CASE_BIT] = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with an occupancy counter. The caller guarantees that
// push only happens when not full and pop only when not empty.
module uart_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage write port.
    // NOTE: the array is deliberately not reset; entries are only read after
    // being written, and leaving it reset-free lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/uart_echo_buf.sv
// Buffered echo engine between uart_rx and uart_tx: FIFO-backed, with
// character, line-buffered and uppercase modes plus overflow statistics.
module uart_echo_buf
    import uart_echo_pkg::*;
#(
    parameter int         DATA_W = 8,
    parameter int         DEPTH  = 16,
    parameter logic [7:0] TERM   = ASCII_CR,
    localparam int        CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_data_valid,
    output logic              rx_data_ready,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_data_valid,
    input  logic              tx_data_ready,
    output logic [CNT_W-1:0]  fifo_count,
    output logic              overflow,
    output logic [7:0]        drop_count
);

    echo_mode_e        cur_mode;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_rd_data;
    logic [DATA_W-1:0] load_data;
    logic [CNT_W-1:0]  lines_pending;
    logic              push;
    logic              pop;
    logic              drop;
    logic              rel_ok;
    logic              push_term;
    logic              pop_term;

    assign cur_mode = echo_mode_e'(mode);

    // Full is the registered count, so a same-cycle pop never rescues a byte.
    assign push = rx_data_valid && !fifo_full;
    assign drop = rx_data_valid && fifo_full;

    // LINE mode holds bytes until a terminator is buffered, or trickles them
    // out when full so a partial line cannot deadlock the receiver.
    assign rel_ok = (cur_mode == MODE_LINE) ? ((lines_pending != '0) || fifo_full) : 1'b1;
    assign pop    = (!tx_data_valid || tx_data_ready) && !fifo_empty && rel_ok;

    assign push_term = push && (rx_data[7:0] == TERM);
    assign pop_term  = pop && (fifo_rd_data[7:0] == TERM);

    assign rx_data_ready = !fifo_full;

    uart_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (rx_data),
        .pop     (pop),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Case conversion applied at load time; the FIFO keeps raw bytes.
    // NOTE: the default assignment up front keeps this block free of latches.
    always_comb begin
        load_data = fifo_rd_data;
        if (cur_mode == MODE_UPPER) begin
            load_data[7:0] = to_upper(fifo_rd_data[7:0]);
        end
    end

    // Number of complete lines currently held in the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            lines_pending <= '0;
        end else begin
            case ({push_term, pop_term})
                2'b10:   lines_pending <= lines_pending + CNT_W'(1);
                2'b01:   lines_pending <= lines_pending - CNT_W'(1);
                default: lines_pending <= lines_pending;
            endcase
        end
    end

    // One-entry output stage holding the byte offered to uart_tx.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data       <= '0;
            tx_data_valid <= 1'b0;
        end else if (pop) begin
            tx_data       <= load_data;
            tx_data_valid <= 1'b1;
        end else if (tx_data_ready) begin
            tx_data_valid <= 1'b0;
        end
    end

    // Sticky overflow flag and saturating dropped-byte counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_uart_echo_buf.sv
// Scoreboard bench for uart_echo_buf: expected bytes are queued as stimulus
// is driven and compared when the tx handshake completes.
module tb_uart_echo_buf;

    localparam int DEPTH = 16;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       mode;
    logic [7:0]       rx_data;
    logic             rx_data_valid;
    logic             rx_data_ready;
    logic [7:0]       tx_data;
    logic             tx_data_valid;
    logic             tx_data_ready;
    logic [CNT_W-1:0] fifo_count;
    logic             overflow;
    logic [7:0]       drop_count;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_xfer  = 0;
    logic [7:0] sb[$];
    logic [7:0] exp_b;

    uart_echo_buf #(.DATA_W(8), .DEPTH(DEPTH), .TERM(8'h0D)) dut (
        .clk           (clk),
        .rst           (rst),
        .mode          (mode),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .rx_data_ready (rx_data_ready),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_data_ready (tx_data_ready),
        .fifo_count    (fifo_count),
        .overflow      (overflow),
        .drop_count    (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] upcase(input logic [7:0] b);
        if (b >= "a" && b <= "z") return b - 8'd32;
        return b;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive a one-cycle strobe; queue the expected echo if it will be accepted.
    task automatic push(input logic [7:0] b, input bit accept, input logic [7:0] exp);
        rx_data       = b;
        rx_data_valid = 1'b1;
        if (accept) sb.push_back(exp);
        tick(1);
        rx_data_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0 && !tx_data_valid) break;
            tick(1);
        end
        check(tag, 32'(sb.size()), 0);
    endtask

    // Monitor: a handshake seen at the falling edge completes at the next rising edge.
    always @(negedge clk) begin
        if (!rst && tx_data_valid && tx_data_ready) begin
            n_xfer++;
            check("sb_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                exp_b = sb.pop_front();
                check("tx_data", 32'(tx_data), 32'(exp_b));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0] char_in [3] = '{8'h41, 8'h42, 8'h43};
    logic [7:0] up_in   [4] = '{8'h61, 8'h7A, 8'h5B, 8'h31};

    initial begin
        int xfer0;
        rst           = 1'b1;
        mode          = 2'd0;
        rx_data       = '0;
        rx_data_valid = 1'b0;
        tx_data_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_tx_valid", 32'(tx_data_valid), 0);
        check("rst_count", 32'(fifo_count), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_drop", 32'(drop_count), 0);
        check("rst_rx_ready", 32'(rx_data_ready), 1);

        // CHAR mode: two-cycle strobe-to-valid latency.
        mode = 2'd0;
        foreach (char_in[i]) begin
            push(char_in[i], 1'b1, char_in[i]);
            check("char_n1_valid", 32'(tx_data_valid), 0);
            check("char_n1_count", 32'(fifo_count), 1);
            tick(1);
            check("char_n2_valid", 32'(tx_data_valid), 1);
            check("char_n2_data", 32'(tx_data), 32'(char_in[i]));
            tick(8);
        end
        check("char_count_end", 32'(fifo_count), 0);
        wait_drain("char_drain", 50);

        // LINE mode: nothing leaves until the terminator arrives.
        mode = 2'd1;
        push(8'h68, 1'b1, 8'h68);
        push(8'h69, 1'b1, 8'h69);
        xfer0 = n_xfer;
        tick(100);
        check("line_hold_xfers", 32'(n_xfer - xfer0), 0);
        check("line_hold_valid", 32'(tx_data_valid), 0);
        check("line_hold_count", 32'(fifo_count), 2);
        push(8'h0D, 1'b1, 8'h0D);
        wait_drain("line_drain", 50);
        check("line_pending_end", 32'(dut.lines_pending), 0);

        // UPPER mode.
        mode = 2'd2;
        foreach (up_in[i]) push(up_in[i], 1'b1, upcase(up_in[i]));
        wait_drain("upper_drain", 50);

        // Overflow: output stage takes the first byte, the FIFO the next DEPTH.
        mode = 2'd0;
        tx_data_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == DEPTH + 1) check("ovf_rx_ready", 32'(rx_data_ready), 0);
            push(8'h80 + 8'(i), i < DEPTH + 1, 8'h80 + 8'(i));
            tick(1);
        end
        check("ovf_count", 32'(fifo_count), DEPTH);
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_drops", 32'(drop_count), 20 - (DEPTH + 1));
        tx_data_ready = 1'b1;
        wait_drain("ovf_drain", 100);
        check("ovf_count_end", 32'(fifo_count), 0);
        check("ovf_sticky", 32'(overflow), 1);

        // LINE mode full without terminator: trickle release, then stall.
        mode = 2'd1;
        tx_data_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            push(8'h20, 1'b1, 8'h20);
            tick(1);
        end
        tick(5);
        check("lfull_count", 32'(fifo_count), DEPTH);
        check("lfull_valid", 32'(tx_data_valid), 1);
        tx_data_ready = 1'b1;
        tick(20);
        check("lfull_stall_count", 32'(fifo_count), DEPTH - 1);
        check("lfull_stall_valid", 32'(tx_data_valid), 0);
        check("lfull_sb_left", 32'(sb.size()), DEPTH - 1);
        mode = 2'd0;
        wait_drain("lfull_drain", 100);

        // Reset with bytes buffered and a pending handshake.
        tx_data_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(8'hA0 + 8'(i), 1'b1, 8'hA0 + 8'(i));
        tick(3);
        check("prerst_count", 32'(fifo_count), 5);
        check("prerst_valid", 32'(tx_data_valid), 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        sb.delete();
        check("rst2_tx_data", 32'(tx_data), 0);
        check("rst2_tx_valid", 32'(tx_data_valid), 0);
        check("rst2_count", 32'(fifo_count), 0);
        check("rst2_overflow", 32'(overflow), 0);
        check("rst2_drop", 32'(drop_count), 0);
        check("rst2_rx_ready", 32'(rx_data_ready), 1);
        tx_data_ready = 1'b1;
        xfer0 = n_xfer;
        push(8'h55, 1'b1, 8'h55);
        wait_drain("rst2_drain", 50);
        check("rst2_xfers", 32'(n_xfer - xfer0), 1);

        tick(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
